// File: rtl/pe_mb.sv
// Weight-stationary systolic MAC PE with a ring of preloadable weight banks.
// Commits fill banks behind the active one; idle cycles (en_in=0) rotate to the next ready bank.
module pe_mb #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int NUM_WBANK  = 2,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en_in,
  input  logic [DATA_WIDTH-1:0]          in,
  input  logic [ACC_WIDTH-1:0]           psum_in,
  input  logic                           w_wen_in,
  input  logic [DATA_WIDTH-1:0]          w_in,
  input  logic                           w_commit_in,
  output logic                           en_out,
  output logic [DATA_WIDTH-1:0]          pass_out,
  output logic [ACC_WIDTH-1:0]           psum_out,
  output logic                           w_wen_out,
  output logic [DATA_WIDTH-1:0]          w_out,
  output logic                           w_commit_out,
  output logic [$clog2(NUM_WBANK):0]     ready_cnt,
  output logic                           err_out
);
  localparam int PW  = $clog2(NUM_WBANK);
  localparam int CW  = PW + 1;
  localparam int PRW = 2 * DATA_WIDTH;
  localparam int PAD = ACC_WIDTH + 1 - PRW;

  logic [DATA_WIDTH-1:0] bank_q [NUM_WBANK];
  logic [PW-1:0]         rd_q, wr_q, rd_d, wr_d;
  logic [CW-1:0]         ready_q, ready_d;
  logic [DATA_WIDTH-1:0] w_q, pass_q;
  logic [ACC_WIDTH-1:0]  psum_q, psum_d;
  logic                  en_q, wen_q, com_q, err_q;
  logic                  swap, commit_ok;

  logic [DATA_WIDTH-1:0] wt;
  logic [PRW-1:0]        a_x, w_x, prod;
  logic [ACC_WIDTH:0]    sum;
  logic                  sgn;

  assign sgn = (SIGNED != 0);
  assign wt  = bank_q[rd_q];

  always_comb begin
    swap      = !en_in && (ready_q != '0);
    commit_ok = w_commit_in && ((ready_q < CW'(NUM_WBANK - 1)) || swap);
    rd_d      = (rd_q == PW'(NUM_WBANK - 1)) ? '0 : rd_q + PW'(1);
    wr_d      = (wr_q == PW'(NUM_WBANK - 1)) ? '0 : wr_q + PW'(1);
    ready_d   = ready_q + CW'(commit_ok) - CW'(swap);
  end

  // Operands extended to the product width so one multiplier serves both signednesses.
  always_comb begin
    a_x    = {{DATA_WIDTH{sgn & in[DATA_WIDTH-1]}}, in};
    w_x    = {{DATA_WIDTH{sgn & wt[DATA_WIDTH-1]}}, wt};
    prod   = a_x * w_x;
    sum    = {{PAD{sgn & prod[PRW-1]}}, prod} + {sgn & psum_in[ACC_WIDTH-1], psum_in};
    psum_d = sum[ACC_WIDTH-1:0];
    if (SATURATE != 0) begin
      if (SIGNED != 0) begin
        if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])
          psum_d = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else if (sum[ACC_WIDTH]) begin
        psum_d = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_WBANK; i++) bank_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= PW'(1);
      ready_q <= '0;
      w_q     <= '0;
      pass_q  <= '0;
      psum_q  <= '0;
      en_q    <= 1'b0;
      wen_q   <= 1'b0;
      com_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      en_q    <= en_in;
      wen_q   <= w_wen_in;
      com_q   <= w_commit_in;
      ready_q <= ready_d;
      if (w_wen_in) w_q <= w_in;
      if (commit_ok) begin
        bank_q[wr_q] <= w_q;
        wr_q         <= wr_d;
      end
      if (w_commit_in && !commit_ok) err_q <= 1'b1;
      if (swap) rd_q <= rd_d;
      if (en_in) begin
        pass_q <= in;
        psum_q <= psum_d;
      end
    end
  end

  assign en_out       = en_q;
  assign pass_out     = pass_q;
  assign psum_out     = psum_q;
  assign w_wen_out    = wen_q;
  assign w_out        = w_q;
  assign w_commit_out = com_q;
  assign ready_cnt    = ready_q;
  assign err_out      = err_q;
endmodule

// File: tb/tb_pe_mb.sv
// Random + directed bench for pe_mb; wrapping and saturating instances share one stimulus
// and are checked against a queue-of-weights reference model.
module tb_pe_mb;
  logic        clk = 1'b0;
  logic        rst, en_in, w_wen_in, w_commit_in;
  logic [15:0] act, w_in;
  logic [39:0] psum_in;

  logic        en_out, w_wen_out, w_commit_out, err_out;
  logic [15:0] pass_out, w_out;
  logic [39:0] psum_out;
  logic [1:0]  ready_cnt;

  logic        s_en_out, s_w_wen_out, s_w_commit_out, s_err_out;
  logic [15:0] s_pass_out, s_w_out;
  logic [39:0] s_psum_out;
  logic [1:0]  s_ready_cnt;

  int nvec = 0;
  int nerr = 0;

  localparam longint MASK = 64'h00FF_FFFF_FFFF;
  localparam longint SMAX = 64'sh007F_FFFF_FFFF;
  localparam longint SMIN = -64'sh0080_0000_0000;

  pe_mb #(.SATURATE(0)) u_dut (
    .clk(clk), .rst(rst), .en_in(en_in), .in(act), .psum_in(psum_in),
    .w_wen_in(w_wen_in), .w_in(w_in), .w_commit_in(w_commit_in),
    .en_out(en_out), .pass_out(pass_out), .psum_out(psum_out),
    .w_wen_out(w_wen_out), .w_out(w_out), .w_commit_out(w_commit_out),
    .ready_cnt(ready_cnt), .err_out(err_out));

  pe_mb #(.SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .en_in(en_in), .in(act), .psum_in(psum_in),
    .w_wen_in(w_wen_in), .w_in(w_in), .w_commit_in(w_commit_in),
    .en_out(s_en_out), .pass_out(s_pass_out), .psum_out(s_psum_out),
    .w_wen_out(s_w_wen_out), .w_out(s_w_out), .w_commit_out(s_w_commit_out),
    .ready_cnt(s_ready_cnt), .err_out(s_err_out));

  always #5 clk = ~clk;

  // Reference state: active weight plus FIFO of committed weights awaiting a swap.
  logic [15:0] m_act, m_wout, m_pass;
  logic [15:0] m_q[$];
  longint      m_psum, m_spsum;
  bit          m_err, m_en, m_wen, m_com;

  function automatic longint mac(input logic [15:0] a, input logic [15:0] w,
                                 input logic [39:0] p, input bit sat);
    longint s;
    s = longint'($signed(a)) * longint'($signed(w)) + longint'($signed(p));
    if (sat) begin
      if (s > SMAX) s = SMAX;
      if (s < SMIN) s = SMIN;
    end
    return s & MASK;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit swp, ok;
    logic [15:0] old_act, old_wout;
    if (rst) begin
      m_act = '0; m_wout = '0; m_pass = '0; m_psum = 0; m_spsum = 0;
      m_q.delete(); m_err = 0; m_en = 0; m_wen = 0; m_com = 0;
      return;
    end
    old_act  = m_act;
    old_wout = m_wout;
    swp = !en_in && (m_q.size() > 0);
    ok  = w_commit_in && ((m_q.size() < 1) || swp);
    if (swp) m_act = m_q.pop_front();
    if (ok) m_q.push_back(old_wout);
    if (w_commit_in && !ok) m_err = 1;
    if (en_in) begin
      m_pass  = act;
      m_psum  = mac(act, old_act, psum_in, 0);
      m_spsum = mac(act, old_act, psum_in, 1);
    end
    if (w_wen_in) m_wout = w_in;
    m_en = en_in; m_wen = w_wen_in; m_com = w_commit_in;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("psum", 64'(psum_out), 64'(m_psum));
    chk("psum_sat", 64'(s_psum_out), 64'(m_spsum));
    chk("pass", 64'(pass_out), 64'(m_pass));
    chk("w_out", 64'(w_out), 64'(m_wout));
    chk("ready", 64'(ready_cnt), 64'(m_q.size()));
    chk("err", 64'(err_out), 64'(m_err));
    chk("en_out", 64'(en_out), 64'(m_en));
    chk("wen_out", 64'(w_wen_out), 64'(m_wen));
    chk("com_out", 64'(w_commit_out), 64'(m_com));
    chk("sat_ready", 64'(s_ready_cnt), 64'(m_q.size()));
  endtask

  task automatic drv(input bit r, input bit e, input logic [15:0] a, input logic [39:0] p,
                     input bit wen, input logic [15:0] w, input bit com);
    rst = r; en_in = e; act = a; psum_in = p; w_wen_in = wen; w_in = w; w_commit_in = com;
    cyc();
  endtask

  initial begin
    rst = 1; en_in = 0; act = 0; psum_in = 0; w_wen_in = 0; w_in = 0; w_commit_in = 0;
    m_q.delete();

    // Reset then a compute with the zero weight
    drv(1, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0);
    drv(0, 1, 16'd5, 40'd7, 0, 0, 0);
    chk("t1_psum", 64'(psum_out), 64'd7);
    chk("t1_pass", 64'(pass_out), 64'd5);
    chk("t1_en", 64'(en_out), 64'd1);
    chk("t1_err", 64'(err_out), 64'd0);
    chk("t1_ready", 64'(ready_cnt), 64'd0);

    // Load weight 3, commit, swap, compute -4*3+10
    drv(0, 0, 0, 0, 1, 16'd3, 0);
    drv(0, 1, 0, 0, 0, 0, 1);
    chk("t2_ready1", 64'(ready_cnt), 64'd1);
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("t2_ready0", 64'(ready_cnt), 64'd0);
    drv(0, 1, 16'hFFFC, 40'd10, 0, 0, 0);
    chk("t2_psum", 64'(psum_out), 64'h00FF_FFFF_FFFE);
    chk("t2_pass", 64'(pass_out), 64'hFFFC);

    // Shift chain
    drv(1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      drv(0, 0, 0, 0, 1, 16'(i), 0);
      chk("t3_wout", 64'(w_out), 64'(i));
      chk("t3_wen", 64'(w_wen_out), 64'd1);
    end
    drv(0, 0, 0, 0, 0, 16'd9, 0);
    chk("t3_hold", 64'(w_out), 64'd3);

    // Overflow with en_in high, then accepted commit alongside a swap
    drv(0, 1, 0, 0, 0, 0, 1);
    chk("t4_ready", 64'(ready_cnt), 64'd1);
    drv(0, 1, 0, 0, 0, 0, 1);
    chk("t4_err", 64'(err_out), 64'd1);
    chk("t4_ready2", 64'(ready_cnt), 64'd1);
    drv(0, 1, 16'd1, 40'd0, 0, 0, 0);
    chk("t4_active", 64'(psum_out), 64'd0);
    chk("t4_sticky", 64'(err_out), 64'd1);
    drv(1, 0, 0, 0, 0, 0, 0);
    drv(0, 1, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 1);
    chk("t4b_err", 64'(err_out), 64'd0);
    chk("t4b_ready", 64'(ready_cnt), 64'd1);

    // Saturation vs wrap
    drv(1, 0, 0, 0, 0, 0, 0);
    drv(0, 1, 0, 0, 1, 16'h7FFF, 0);
    drv(0, 1, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 0);
    drv(0, 1, 16'h7FFF, 40'h7F_FFFF_FFFF, 0, 0, 0);
    chk("t5_sat", 64'(s_psum_out), 64'h7F_FFFF_FFFF);
    chk("t5_wrap", 64'(psum_out), 64'h80_3FFF_0000);

    // Mid-load reset clears the loaded weight bank
    drv(0, 0, 0, 0, 1, 16'd1, 0);
    drv(1, 0, 0, 0, 1, 16'd2, 0);
    chk("t6_wout", 64'(w_out), 64'd0);
    chk("t6_ready", 64'(ready_cnt), 64'd0);
    chk("t6_psum", 64'(psum_out), 64'd0);
    drv(0, 1, 16'd5, 40'd0, 1, 16'd3, 0);
    chk("t6_bank0", 64'(psum_out), 64'd0);
    chk("t6_wout3", 64'(w_out), 64'd3);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [39:0] p;
      case ($urandom_range(0, 3))
        0: p = 40'h7F_FFFF_FFFF - 40'($urandom_range(0, 1 << 20));
        1: p = 40'h80_0000_0000 + 40'($urandom_range(0, 1 << 20));
        default: p = {8'($urandom), 32'($urandom)};
      endcase
      drv(($urandom_range(0, 63) == 0), $urandom_range(0, 1), 16'($urandom), p,
          $urandom_range(0, 1), 16'($urandom), ($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
